uart_rx_sampler: RTL and testbench
==================================

# uart_rx_sampler

Serial UART receiver that consumes the 16x-oversampling enable strobe (`rx_en`) from the baud-rate generator and recovers 8N1 frames from the `rx` line. Synchronises `rx`, qualifies the start bit at mid-bit, samples each data bit at its centre (LSB first), checks the stop bit, and presents the byte on a held output with a ready flag. It sits directly downstream of the baud-rate generator and upstream of whatever host logic reads received bytes.

## Interface
- `DATA_BITS`, 8, data bits per frame (LSB first).
- `OVERSAMPLE`, 16, `rx_en` strobes per bit period; must be even and at least 4.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `rx_en`  input  1  one-`clk`-wide strobe at OVERSAMPLE x baud rate.
- `rx`  input  1  asynchronous serial line, idle high.
- `rdy_clr`  input  1  host acknowledge; clears `rdy` and `overrun`.
- `data`  output  DATA_BITS  last good received byte, held until the next good frame.
- `rdy`  output  1  a good frame is waiting in `data`.
- `ferr`  output  1  the last completed frame had a low stop bit.
- `overrun`  output  1  a good frame completed while `rdy` was still set.

## Operation
- **Synchroniser.** `rx` passes through 2 flops, both reset to 1. All decisions use the second flop, `rx_s`.
- **Counters.** `smp_cnt` runs 0..OVERSAMPLE-1. `bit_idx` runs 0..DATA_BITS-1. The shift register `shreg` is DATA_BITS wide.
- **Advance rule.** The FSM advances only in cycles where `rx_en`=1. With `rx_en`=0, all FSM state and counters hold.
- **IDLE.** If `rx_s`=0 on a tick: go to START with `smp_cnt`=0. Otherwise stay.
- **START.** On each tick, if `smp_cnt`==OVERSAMPLE/2-1:
  - `rx_s`=0: go to DATA with `smp_cnt`=0 and `bit_idx`=0.
  - `rx_s`=1: treat as a glitch and return to IDLE. No flags change.
  - Otherwise `smp_cnt`++.
- **DATA.** On each tick, if `smp_cnt`==OVERSAMPLE-1:
  - Set `shreg[bit_idx]` to `rx_s` and set `smp_cnt`=0.
  - If `bit_idx`==DATA_BITS-1, go to STOP. Otherwise `bit_idx`++.
  - Otherwise `smp_cnt`++.
- **STOP.** On each tick, if `smp_cnt`==OVERSAMPLE-1, go to IDLE and resolve the frame:
  - `rx_s`=1 (good frame): `data`<=`shreg`, `rdy`<=1, `ferr`<=0. Also `overrun`<=1 if `rdy` was already 1 and `rdy_clr`=0 in this cycle.
  - `rx_s`=0 (framing error): `ferr`<=1. `data`, `rdy` and `overrun` are unchanged.
  - Otherwise `smp_cnt`++.
- **Break condition.** A line held low re-enters START on the first tick in IDLE. It produces repeated framing errors with `data` = 0x00 never committed.
- **`rdy_clr`.**
  - Takes effect in any state on any cycle, independent of `rx_en`: `rdy`<=0, `overrun`<=0.
  - It does not affect `ferr` or `data`.
  - If it coincides with a good-frame completion, the completion wins: `rdy`=1, `overrun`=0.
- **Reset values:** state=IDLE, counters=0, `shreg`=0, `data`=0, `rdy`=0, `ferr`=0, `overrun`=0. Reset mid-frame abandons the frame with no flag set.

## Timing
- **Sampling points.** Ticks are numbered from the first tick in IDLE that sees `rx_s`=0, counting that tick as tick 0:
  - Start bit is re-checked at tick OVERSAMPLE/2 (tick 8).
  - Data bit k is sampled at tick 8+16(k+1) (bits at ticks 24..136).
  - Stop bit is sampled at tick 152.
  - All sampling points are nominal bit centres, with ±1 tick of quantisation.
- **Output latency.** `rdy`, `data`, `ferr` and `overrun` update on the `clk` edge that ends the stop-sample tick cycle. They are registered and glitch-free.
- **Synchroniser delay.** `rx` reaches `rx_s` 2 clk edges after it changes.
- **Back-to-back frames.** A new start bit may begin immediately after the stop sample. IDLE is entered in the same cycle, so a frame with a single stop bit is received without loss.
- **Error tolerance.** Tolerates ±3% baud mismatch.

## Test plan
- **Basic byte.** Reset, then `rx_en` every 4 clk. Send 0xA5 as 8N1 at 64 clk/bit. Required: `data`=0xA5, `rdy`=1, `ferr`=0, `overrun`=0. `rdy`=0 one clk after a single-cycle `rdy_clr`.
- **Back-to-back and overrun.** Send 0x00, 0xFF, 0x3C with no gap and no `rdy_clr`. Required: `data` steps 0x00 → 0xFF → 0x3C. `overrun`=1 after the second frame and stays 1. `rdy_clr` clears both flags.
- **Framing error.** Send 0x55 with stop bit 0. Required: `ferr`=1, and `rdy`/`data` keep their prior values. Next good 0x12 gives `ferr`=0, `data`=0x12.
- **Start glitch.** Pulse `rx` low for 4 ticks (< 8), then send 0x81. Required: the glitch produces no flags, and 0x81 is received correctly.
- **Async reset mid-frame.** Assert `rst_n`=0 during data bit 3, release it, then send 0xC3. Required: all outputs 0 during reset, and only 0xC3 is reported afterwards.
- **Coincident clear and completion.** Drive `rdy_clr`=1 in the exact stop-sample cycle while `rdy`=1. Required: `rdy`=1, `overrun`=0, `data` holds the new byte.

Source files
------------

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: 8N1 UART receiver driven by a 16x oversampling strobe.
// Synchronises rx, centre-samples start/data/stop and holds the last good byte.
module uart_rx_sampler #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_en,
    input  logic                 rx,
    input  logic                 rdy_clr,
    output logic [DATA_BITS-1:0] data,
    output logic                 rdy,
    output logic                 ferr,
    output logic                 overrun
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] FULL_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t               state;
    logic [SW-1:0]        smp_cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 rx_meta;
    logic                 rx_s;

    // Idle-high synchroniser so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            smp_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            data    <= '0;
            rdy     <= 1'b0;
            ferr    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (rdy_clr) begin
                rdy     <= 1'b0;
                overrun <= 1'b0;
            end
            if (rx_en) begin
                unique case (state)
                    S_IDLE: begin
                        if (!rx_s) begin
                            state   <= S_START;
                            smp_cnt <= '0;
                        end
                    end
                    S_START: begin
                        if (smp_cnt == HALF_LAST) begin
                            if (!rx_s) begin
                                state   <= S_DATA;
                                smp_cnt <= '0;
                                bit_idx <= '0;
                            end else begin
                                state <= S_IDLE;
                            end
                        end else begin
                            smp_cnt <= smp_cnt + 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (smp_cnt == FULL_LAST) begin
                            shreg[bit_idx] <= rx_s;
                            smp_cnt        <= '0;
                            if (bit_idx == LAST_BIT) begin
                                state <= S_STOP;
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                            end
                        end else begin
                            smp_cnt <= smp_cnt + 1'b1;
                        end
                    end
                    S_STOP: begin
                        if (smp_cnt == FULL_LAST) begin
                            state   <= S_IDLE;
                            smp_cnt <= '0;
                            // A completing good frame overrides a same-cycle clear.
                            if (rx_s) begin
                                data <= shreg;
                                rdy  <= 1'b1;
                                ferr <= 1'b0;
                                if (rdy && !rdy_clr) begin
                                    overrun <= 1'b1;
                                end
                            end else begin
                                ferr <= 1'b1;
                            end
                        end else begin
                            smp_cnt <= smp_cnt + 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb_uart_rx_sampler: directed 8N1 frames with a scoreboard of expected
// output states, popped by a monitor whenever the DUT outputs change.
module tb_uart_rx_sampler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_en;
    logic       rx;
    logic       rdy_clr;
    logic [7:0] data;
    logic       rdy;
    logic       ferr;
    logic       overrun;

    always #5 clk = ~clk;

    uart_rx_sampler #(
        .DATA_BITS (8),
        .OVERSAMPLE(16)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .rx_en  (rx_en),
        .rx     (rx),
        .rdy_clr(rdy_clr),
        .data   (data),
        .rdy    (rdy),
        .ferr   (ferr),
        .overrun(overrun)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       r;
        logic       f;
        logic       o;
    } st_t;

    st_t q[$];
    st_t m;
    st_t lastexp;
    st_t prev;
    st_t now;
    st_t e;
    int  passed = 0;
    int  total = 0;
    int  cyc = 0;
    bit  mon_on = 1'b0;

    // Monitor: every change of the output state must match the next expectation.
    always @(negedge clk) begin
        if (mon_on) begin
            now = {data, rdy, ferr, overrun};
            if (now !== prev) begin
                total++;
                if (q.size() == 0) begin
                    $display("FAIL mon_unexpected: got d=%h r=%b f=%b o=%b, none expected",
                             now.d, now.r, now.f, now.o);
                end else begin
                    e = q.pop_front();
                    if (now === e) begin
                        passed++;
                    end else begin
                        $display("FAIL mon: got d=%h r=%b f=%b o=%b exp d=%h r=%b f=%b o=%b",
                                 now.d, now.r, now.f, now.o, e.d, e.r, e.f, e.o);
                    end
                end
                prev = now;
            end
        end
    end

    task automatic tick_clk();
        @(negedge clk);
        cyc++;
        rx_en = (cyc % 4 == 0);
    endtask

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h exp %h", nm, got, exp);
    endtask

    task automatic push();
        if (m != lastexp) begin
            q.push_back(m);
            lastexp = m;
        end
    endtask

    task automatic model_frame(input logic [7:0] b, input bit good, input bit clr);
        if (good) begin
            m.o = (m.r && !clr) ? 1'b1 : (clr ? 1'b0 : m.o);
            m.d = b;
            m.r = 1'b1;
            m.f = 1'b0;
        end else begin
            m.f = 1'b1;
            if (clr) begin
                m.r = 1'b0;
                m.o = 1'b0;
            end
        end
        push();
    endtask

    // Frame starts on a fixed strobe phase so the stop-sample cycle is k=610.
    task automatic send_frame(input logic [7:0] b, input bit good,
                              input bit clr, input int abort_at);
        int bi;
        while (cyc % 4 != 2) tick_clk();
        for (int k = 0; k < 640; k++) begin
            if (k == abort_at) return;
            if (k % 64 == 0) begin
                bi = k / 64;
                if (bi == 0) rx = 1'b0;
                else if (bi == 9) rx = good;
                else rx = b[bi-1];
            end
            rdy_clr = clr && (k == 610);
            tick_clk();
        end
        rdy_clr = 1'b0;
        rx = 1'b1;
    endtask

    task automatic clear();
        m.r = 1'b0;
        m.o = 1'b0;
        push();
        rdy_clr = 1'b1;
        tick_clk();
        rdy_clr = 1'b0;
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 40 && q.size() != 0; i++) tick_clk();
        total++;
        if (q.size() == 0) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d pending expectations, exp 0", nm, q.size());
            q.delete();
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        rx      = 1'b1;
        rx_en   = 1'b0;
        rdy_clr = 1'b0;
        repeat (5) tick_clk();
        chk("reset_data", data, 8'h00);
        chk("reset_rdy", {7'd0, rdy}, 8'h00);
        chk("reset_ferr", {7'd0, ferr}, 8'h00);
        chk("reset_ovr", {7'd0, overrun}, 8'h00);
        rst_n   = 1'b1;
        m       = '0;
        lastexp = '0;
        prev    = {data, rdy, ferr, overrun};
        mon_on  = 1'b1;
        repeat (10) tick_clk();

        model_frame(8'hA5, 1'b1, 1'b0);
        send_frame(8'hA5, 1'b1, 1'b0, -1);
        drain("basic_a5");
        clear();
        drain("basic_clr");

        model_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'h00, 1'b1, 1'b0, -1);
        model_frame(8'hFF, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0, -1);
        model_frame(8'h3C, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0, -1);
        drain("b2b");
        chk("b2b_ovr", {7'd0, overrun}, 8'h01);
        clear();
        drain("b2b_clr");

        model_frame(8'h77, 1'b1, 1'b0);
        send_frame(8'h77, 1'b1, 1'b0, -1);
        model_frame(8'h55, 1'b0, 1'b0);
        send_frame(8'h55, 1'b0, 1'b0, -1);
        repeat (200) tick_clk();
        chk("ferr_data_held", data, 8'h77);
        model_frame(8'h12, 1'b1, 1'b0);
        send_frame(8'h12, 1'b1, 1'b0, -1);
        drain("ferr_recover");
        clear();
        drain("ferr_clr");

        while (cyc % 4 != 2) tick_clk();
        rx = 1'b0;
        repeat (16) tick_clk();
        rx = 1'b1;
        repeat (200) tick_clk();
        model_frame(8'h81, 1'b1, 1'b0);
        send_frame(8'h81, 1'b1, 1'b0, -1);
        drain("glitch_81");

        send_frame(8'h5A, 1'b1, 1'b0, 64 * 4 + 32);
        m = '0;
        push();
        rst_n = 1'b0;
        repeat (10) tick_clk();
        chk("rst_mid_data", data, 8'h00);
        chk("rst_mid_rdy", {7'd0, rdy}, 8'h00);
        chk("rst_mid_ferr", {7'd0, ferr}, 8'h00);
        chk("rst_mid_ovr", {7'd0, overrun}, 8'h00);
        rx = 1'b1;
        rst_n = 1'b1;
        repeat (50) tick_clk();
        drain("rst_mid");
        model_frame(8'hC3, 1'b1, 1'b0);
        send_frame(8'hC3, 1'b1, 1'b0, -1);
        drain("after_rst_c3");

        model_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h11, 1'b1, 1'b0, -1);
        model_frame(8'h9E, 1'b1, 1'b1);
        send_frame(8'h9E, 1'b1, 1'b1, -1);
        drain("coincident");
        chk("coinc_rdy", {7'd0, rdy}, 8'h01);
        chk("coinc_ovr", {7'd0, overrun}, 8'h00);
        chk("coinc_data", data, 8'h9E);

        repeat (20) tick_clk();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
